mc_main_ctrl: RTL and testbench

Multi-cycle main control FSM for the MIPS core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. It drives the 6-bit ALU-operation code consumed by `aluCtrl`, the datapath mux selects, register/PC write enables and a ready-handshaked memory port. The single shared ALU is time-multiplexed between PC increment, branch-target calculation and instruction execution.

---
 rtl/mc_main_ctrl_pkg.sv | 42 ++++
 rtl/mc_main_ctrl_if.sv | 16 +
 rtl/mc_main_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mc_main_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_main_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multi-cycle MIPS main controller.
// Holds the opcode and funct constants decoded by the control FSM, the
// alu_op codes consumed by aluCtrl, and the 4-bit controller state type.
package mips_ctrl_pkg;

    // instruction[31:26]
    localparam logic [5:0] OP_R        = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SW       = 6'b101011;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_J        = 6'b000010;

    // instruction[5:0] under SPECIAL2
    localparam logic [5:0] FN_CLZ = 6'b100000;
    localparam logic [5:0] FN_CLO = 6'b100001;

    // alu_op codes for aluCtrl
    localparam logic [5:0] ALU_RTYPE = 6'b000000;
    localparam logic [5:0] ALU_CLX   = 6'b000001;
    localparam logic [5:0] ALU_ADD   = 6'b000010;
    localparam logic [5:0] ALU_SUB   = 6'b000011;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_R_EXEC   = 4'd3,
        ST_R_WB     = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WB   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_I_EXEC   = 4'd9,
        ST_I_WB     = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_ILLEGAL  = 4'd13
    } state_e;

endpackage

// File: rtl/mc_main_ctrl_if.sv
// mc_main_ctrl_if: ready-handshaked memory port of the main controller.
//   mem_read / mem_write : request, held until the edge where mem_ready=1
//   i_or_d               : 0 = address from PC, 1 = address from ALUOut
//   mem_ready            : memory completes the current access this edge
// master = controller side, slave = memory side.
interface mc_main_ctrl_if;
    logic mem_read;
    logic mem_write;
    logic i_or_d;
    logic mem_ready;

    modport master (output mem_read, output mem_write, output i_or_d,
                    input  mem_ready);
    modport slave  (input  mem_read, input  mem_write, input  i_or_d,
                    output mem_ready);
endinterface

// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: multi-cycle main control FSM for the MIPS core.
// Sequences one instruction through fetch, decode, execute, memory and
// writeback, time-multiplexing the single ALU between PC increment,
// branch-target calculation and execution.
// Ports:
//   clk, reset          : rising-edge clock, async active-high reset
//   opcode, funct       : fields from the external IR
//   mem (master)        : memory request/ready handshake and address select
//   ir_write, pc_write, pc_write_cond, pc_source : IR / PC update controls
//   alu_op, alu_src_a, alu_src_b                 : ALU operation and operands
//   reg_dst, mem_to_reg, reg_write               : register-file writeback
//   retire, illegal_op  : one-cycle end-of-instruction pulses
module mc_main_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    mc_main_ctrl_if.master       mem,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic [1:0]           pc_source,
    output logic [5:0]           alu_op,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 retire,
    output logic                 illegal_op
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:    state_d = ST_FETCH;
            ST_FETCH:    if (mem.mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_R:        state_d = ST_R_EXEC;
                    OP_SPECIAL2: state_d = (funct == FN_CLZ || funct == FN_CLO)
                                           ? ST_R_EXEC : ST_ILLEGAL;
                    OP_LW,
                    OP_SW:       state_d = ST_MEM_ADDR;
                    OP_ADDI:     state_d = ST_I_EXEC;
                    OP_BEQ:      state_d = ST_BRANCH;
                    OP_J:        state_d = ST_JUMP;
                    default:     state_d = ST_ILLEGAL;
                endcase
            end
            ST_R_EXEC:   state_d = ST_R_WB;
            // Only LW and SW reach MEM_ADDR, so one compare selects the path.
            ST_MEM_ADDR: state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (mem.mem_ready) state_d = ST_MEM_WB;
            ST_MEM_WR:   if (mem.mem_ready) state_d = ST_FETCH;
            ST_I_EXEC:   state_d = ST_I_WB;
            ST_R_WB,
            ST_MEM_WB,
            ST_I_WB,
            ST_BRANCH,
            ST_JUMP,
            ST_ILLEGAL:  state_d = ST_FETCH;
            default:     state_d = ST_FETCH;
        endcase
    end

    // Output decode from the state register; mem_ready only qualifies the
    // IR/PC load in FETCH and the retire pulse in MEM_WR.
    always_comb begin
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        mem.i_or_d    = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        alu_op        = ALU_RTYPE;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        retire        = 1'b0;
        illegal_op    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem.mem_read = 1'b1;
                alu_src_b    = 2'b01;
                alu_op       = ALU_ADD;
                ir_write     = mem.mem_ready;
                pc_write     = mem.mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALU_ADD;
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = (opcode == OP_SPECIAL2) ? ALU_CLX : ALU_RTYPE;
            end
            ST_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            ST_MEM_ADDR,
            ST_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                mem.mem_read = 1'b1;
                mem.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            ST_MEM_WR: begin
                mem.mem_write = 1'b1;
                mem.i_or_d    = 1'b1;
                retire        = mem.mem_ready;
            end
            ST_I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire        = 1'b1;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire    = 1'b1;
            end
            ST_ILLEGAL: begin
                illegal_op = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb_mc_main_ctrl: directed vector table plus hand sequences and a
// random mem_ready run for mc_main_ctrl.
module tb_mc_main_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       ir_write, pc_write, pc_write_cond, reg_dst, mem_to_reg;
    logic       reg_write, retire, illegal_op, alu_src_a;
    logic [1:0] pc_source, alu_src_b;
    logic [5:0] alu_op;

    mc_main_ctrl_if mem_if();

    always #5 clk = ~clk;

    mc_main_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .mem           (mem_if),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .retire        (retire),
        .illegal_op    (illegal_op)
    );

    typedef struct {
        string      name;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic       rdy;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad = 0;

    // Field order: mr mw iod irw pcw pcc ps[2] op[6] a b[2] rd m2r rw ret ill
    function automatic logic [21:0] mk(input logic mr, input logic mw, input logic iod,
                                       input logic irw, input logic pcw, input logic pcc,
                                       input logic [1:0] ps, input logic [5:0] op,
                                       input logic a, input logic [1:0] b, input logic rd,
                                       input logic m2r, input logic rw, input logic ret,
                                       input logic ill);
        return {mr, mw, iod, irw, pcw, pcc, ps, op, a, b, rd, m2r, rw, ret, ill};
    endfunction

    function automatic logic [21:0] act_w();
        return mk(mem_if.mem_read, mem_if.mem_write, mem_if.i_or_d, ir_write, pc_write,
                  pc_write_cond, pc_source, alu_op, alu_src_a, alu_src_b, reg_dst,
                  mem_to_reg, reg_write, retire, illegal_op);
    endfunction

    task automatic chk(input string n, input logic [21:0] a, input logic [21:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %b want %b", n, a, e);
        end
    endtask

    task automatic add(input string n, input logic [5:0] op, input logic [5:0] fn,
                       input logic rdy, input logic [21:0] e);
        vec_t v;
        v.name = n; v.opcode = op; v.funct = fn; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endtask

    logic [21:0] E_ZERO, E_FETCH_R, E_FETCH_W, E_DEC, E_REX, E_S2EX, E_RWB, E_MA;
    logic [21:0] E_MRD, E_MWB, E_MWR_W, E_MWR_R, E_IWB, E_BR, E_J, E_ILL;

    logic [5:0] c_op[11];
    logic [5:0] c_fn[11];
    logic       c_legal[11];

    initial begin
        E_ZERO    = '0;
        E_FETCH_R = mk(1,0,0,1,1,0,2'b00,6'b000010,0,2'b01,0,0,0,0,0);
        E_FETCH_W = mk(1,0,0,0,0,0,2'b00,6'b000010,0,2'b01,0,0,0,0,0);
        E_DEC     = mk(0,0,0,0,0,0,2'b00,6'b000010,0,2'b11,0,0,0,0,0);
        E_REX     = mk(0,0,0,0,0,0,2'b00,6'b000000,1,2'b00,0,0,0,0,0);
        E_S2EX    = mk(0,0,0,0,0,0,2'b00,6'b000001,1,2'b00,0,0,0,0,0);
        E_RWB     = mk(0,0,0,0,0,0,2'b00,6'b000000,0,2'b00,1,0,1,1,0);
        E_MA      = mk(0,0,0,0,0,0,2'b00,6'b000010,1,2'b10,0,0,0,0,0);
        E_MRD     = mk(1,0,1,0,0,0,2'b00,6'b000000,0,2'b00,0,0,0,0,0);
        E_MWB     = mk(0,0,0,0,0,0,2'b00,6'b000000,0,2'b00,0,1,1,1,0);
        E_MWR_W   = mk(0,1,1,0,0,0,2'b00,6'b000000,0,2'b00,0,0,0,0,0);
        E_MWR_R   = mk(0,1,1,0,0,0,2'b00,6'b000000,0,2'b00,0,0,0,1,0);
        E_IWB     = mk(0,0,0,0,0,0,2'b00,6'b000000,0,2'b00,0,0,1,1,0);
        E_BR      = mk(0,0,0,0,0,1,2'b01,6'b000011,1,2'b00,0,0,0,1,0);
        E_J       = mk(0,0,0,0,1,0,2'b10,6'b000000,0,2'b00,0,0,0,1,0);
        E_ILL     = mk(0,0,0,0,0,0,2'b00,6'b000000,0,2'b00,0,0,0,0,1);

        // ADD (R-type)
        add("add.fetch", 6'h00, 6'h20, 1, E_FETCH_R);
        add("add.dec",   6'h00, 6'h20, 1, E_DEC);
        add("add.exec",  6'h00, 6'h20, 1, E_REX);
        add("add.wb",    6'h00, 6'h20, 1, E_RWB);
        // LW, one fetch wait, three MEM_RD wait cycles
        add("lw.fwait",  6'h23, 6'h00, 0, E_FETCH_W);
        add("lw.fetch",  6'h23, 6'h00, 1, E_FETCH_R);
        add("lw.dec",    6'h23, 6'h00, 1, E_DEC);
        add("lw.addr",   6'h23, 6'h00, 1, E_MA);
        add("lw.rd0",    6'h23, 6'h00, 0, E_MRD);
        add("lw.rd1",    6'h23, 6'h00, 0, E_MRD);
        add("lw.rd2",    6'h23, 6'h00, 0, E_MRD);
        add("lw.rd3",    6'h23, 6'h00, 1, E_MRD);
        add("lw.wb",     6'h23, 6'h00, 1, E_MWB);
        // SW with one write wait
        add("sw.fetch",  6'h2b, 6'h00, 1, E_FETCH_R);
        add("sw.dec",    6'h2b, 6'h00, 1, E_DEC);
        add("sw.addr",   6'h2b, 6'h00, 1, E_MA);
        add("sw.wait",   6'h2b, 6'h00, 0, E_MWR_W);
        add("sw.done",   6'h2b, 6'h00, 1, E_MWR_R);
        // ADDI; mem_ready low in non-memory states must be ignored
        add("addi.fetch",6'h08, 6'h00, 1, E_FETCH_R);
        add("addi.dec",  6'h08, 6'h00, 0, E_DEC);
        add("addi.exec", 6'h08, 6'h00, 0, E_MA);
        add("addi.wb",   6'h08, 6'h00, 0, E_IWB);
        // SPECIAL2 CLO / CLZ / bad funct
        add("clo.fetch", 6'h1c, 6'h21, 1, E_FETCH_R);
        add("clo.dec",   6'h1c, 6'h21, 1, E_DEC);
        add("clo.exec",  6'h1c, 6'h21, 1, E_S2EX);
        add("clo.wb",    6'h1c, 6'h21, 1, E_RWB);
        add("clz.fetch", 6'h1c, 6'h20, 1, E_FETCH_R);
        add("clz.dec",   6'h1c, 6'h20, 1, E_DEC);
        add("clz.exec",  6'h1c, 6'h20, 1, E_S2EX);
        add("clz.wb",    6'h1c, 6'h20, 1, E_RWB);
        add("s2bad.fetch",6'h1c,6'h3f, 1, E_FETCH_R);
        add("s2bad.dec", 6'h1c, 6'h3f, 1, E_DEC);
        add("s2bad.ill", 6'h1c, 6'h3f, 1, E_ILL);
        // BEQ, J, illegal opcode
        add("beq.fetch", 6'h04, 6'h00, 1, E_FETCH_R);
        add("beq.dec",   6'h04, 6'h00, 1, E_DEC);
        add("beq.br",    6'h04, 6'h00, 1, E_BR);
        add("j.fetch",   6'h02, 6'h00, 1, E_FETCH_R);
        add("j.dec",     6'h02, 6'h00, 1, E_DEC);
        add("j.jump",    6'h02, 6'h00, 1, E_J);
        add("ill.fetch", 6'h3f, 6'h00, 1, E_FETCH_R);
        add("ill.dec",   6'h3f, 6'h00, 1, E_DEC);
        add("ill.ill",   6'h3f, 6'h00, 1, E_ILL);

        // Reset held, then one RESET cycle after release
        mem_if.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("reset_held", act_w(), E_ZERO);
        @(negedge clk) reset = 1'b0;
        #1 chk("reset_state", act_w(), E_ZERO);

        foreach (vecs[i]) begin
            @(negedge clk);
            opcode = vecs[i].opcode;
            funct  = vecs[i].funct;
            mem_if.mem_ready = vecs[i].rdy;
            #1 chk(vecs[i].name, act_w(), vecs[i].exp);
        end

        // Reset asserted mid-write with mem_ready low
        @(negedge clk); opcode = 6'h2b; mem_if.mem_ready = 1'b1;
        #1 chk("rst.fetch", act_w(), E_FETCH_R);
        @(negedge clk); #1 chk("rst.dec", act_w(), E_DEC);
        @(negedge clk); #1 chk("rst.addr", act_w(), E_MA);
        @(negedge clk); mem_if.mem_ready = 1'b0;
        #1 chk("rst.wrwait", act_w(), E_MWR_W);
        #2 reset = 1'b1;
        #1 chk("rst.async", act_w(), E_ZERO);
        @(negedge clk) reset = 1'b0;
        #1 chk("rst.released", act_w(), E_ZERO);
        @(negedge clk); mem_if.mem_ready = 1'b1;
        #1 chk("rst.refetch", act_w(), E_FETCH_R);
        @(negedge clk); #1 chk("rst.redec", act_w(), E_DEC);
        @(negedge clk); #1 chk("rst.readdr", act_w(), E_MA);
        @(negedge clk); #1 chk("rst.rewr", act_w(), E_MWR_R);

        // Random mem_ready over 200 instructions
        c_op = '{6'h00, 6'h1c, 6'h1c, 6'h1c, 6'h23, 6'h2b, 6'h08, 6'h04, 6'h02, 6'h3f, 6'h05};
        c_fn = '{6'h20, 6'h21, 6'h20, 6'h3f, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        c_legal = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        begin
            int done = 0, legal_n = 0, illeg_n = 0, ret_n = 0, ill_n = 0, cyc = 0, k;
            logic prev_mr = 1'b0, prev_mw = 1'b0, prev_rdy = 1'b0, need_new = 1'b1;
            while (done < 200 && cyc < 20000) begin
                @(negedge clk);
                if (need_new) begin
                    k = int'($urandom_range(0, 10));
                    opcode = c_op[k];
                    funct  = c_fn[k];
                    if (c_legal[k]) legal_n++; else illeg_n++;
                    need_new = 1'b0;
                end
                mem_if.mem_ready = ($urandom_range(0, 2) != 0);
                #1;
                cyc++;
                total++;
                if (mem_if.mem_read && mem_if.mem_write) begin
                    bad++; $display("FAIL rnd_excl_rw: got both high at cycle %0d, want at most one", cyc);
                end
                total++;
                if (retire && illegal_op) begin
                    bad++; $display("FAIL rnd_excl_ret: got both high at cycle %0d, want at most one", cyc);
                end
                if (prev_mr && !prev_rdy) begin
                    total++;
                    if (!mem_if.mem_read) begin
                        bad++; $display("FAIL rnd_rd_hold: got mem_read=0 at cycle %0d, want 1", cyc);
                    end
                end
                if (prev_mw && !prev_rdy) begin
                    total++;
                    if (!mem_if.mem_write) begin
                        bad++; $display("FAIL rnd_wr_hold: got mem_write=0 at cycle %0d, want 1", cyc);
                    end
                end
                prev_mr  = mem_if.mem_read;
                prev_mw  = mem_if.mem_write;
                prev_rdy = mem_if.mem_ready;
                if (retire) ret_n++;
                if (illegal_op) ill_n++;
                if (retire || illegal_op) begin
                    done++;
                    need_new = 1'b1;
                end
            end
            total++;
            if (done != 200) begin
                bad++; $display("FAIL rnd_timeout: got %0d completed, want 200", done);
            end
            total++;
            if (ret_n != legal_n) begin
                bad++; $display("FAIL rnd_retire_cnt: got %0d, want %0d", ret_n, legal_n);
            end
            total++;
            if (ill_n != illeg_n) begin
                bad++; $display("FAIL rnd_illegal_cnt: got %0d, want %0d", ill_n, illeg_n);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
